// File: rtl/reg_file_sc_if.sv
// Bus bundle for reg_file_sc: two combinational read ports, one clocked write
// port, and the ready/wr_err status lines.
interface reg_file_sc_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] readreg_1;
  logic [ADDR_W-1:0] readreg_2;
  logic [DATA_W-1:0] regdat_1;
  logic [DATA_W-1:0] regdat_2;
  logic              regwrite;
  logic [ADDR_W-1:0] write_add;
  logic [DATA_W-1:0] write_dat;
  logic              ready;
  logic              wr_err;

  // regwrite is a single-cycle request sampled at each rising edge; it is
  // accepted only while ready is high, otherwise it is dropped and flagged on wr_err.
  modport master (
    output readreg_1, readreg_2, regwrite, write_add, write_dat,
    input  regdat_1, regdat_2, ready, wr_err
  );

  modport slave (
    input  readreg_1, readreg_2, regwrite, write_add, write_dat,
    output regdat_1, regdat_2, ready, wr_err
  );
endinterface

// File: rtl/reg_file_sc.sv
// Synchronous register file with hardwired zero entry, write-to-read bypass and
// a post-reset clear sweep that zeroes one entry per cycle before raising ready.
module reg_file_sc #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic          clk,
  input  logic          rst,
  reg_file_sc_if.slave  bus,
  output logic          dbg_state_o
);

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  localparam logic [ADDR_W:0]   NUM_REGS_W = (ADDR_W+1)'(NUM_REGS);
  localparam logic [ADDR_W-1:0] LAST_PTR   = ADDR_W'(NUM_REGS - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
  logic              wr_err_q, wr_err_d;
  logic [DATA_W-1:0] mem_q [NUM_REGS];

  logic is_run;
  logic wr_in_range;
  logic wr_zero_drop;
  logic wr_accept;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < NUM_REGS_W);
  endfunction

  assign is_run       = (state_q == ST_RUN);
  assign wr_in_range  = in_range(bus.write_add);
  assign wr_zero_drop = (ZERO_REG != 0) && (bus.write_add == '0);
  assign wr_accept    = is_run && bus.regwrite && wr_in_range && !wr_zero_drop;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_CLEAR;
      clr_ptr_q <= '0;
      wr_err_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
      wr_err_q  <= wr_err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    wr_err_d  = bus.regwrite && (!is_run || !wr_in_range);
    case (state_q)
      ST_CLEAR: begin
        clr_ptr_d = clr_ptr_q + 1'b1;
        if (clr_ptr_q == LAST_PTR) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_CLEAR;
      end
    endcase
  end

  // Array has no reset: its contents become defined only through the sweep.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == ST_CLEAR) begin
        mem_q[clr_ptr_q] <= '0;
      end else if (wr_accept) begin
        mem_q[bus.write_add] <= bus.write_dat;
      end
    end
  end

  function automatic logic [DATA_W-1:0] rd_mux(input logic [ADDR_W-1:0] addr);
    logic [DATA_W-1:0] v;
    v = '0;
    if (!is_run) begin
      v = '0;
    end else if (!in_range(addr)) begin
      v = '0;
    end else if ((ZERO_REG != 0) && (addr == '0)) begin
      v = '0;
    end else if ((BYPASS != 0) && wr_accept && (bus.write_add == addr)) begin
      v = bus.write_dat;
    end else begin
      v = mem_q[addr];
    end
    return v;
  endfunction

  always_comb begin
    bus.regdat_1 = '0;
    bus.regdat_2 = '0;
    bus.regdat_1 = rd_mux(bus.readreg_1);
    bus.regdat_2 = rd_mux(bus.readreg_2);
  end

  assign bus.ready   = is_run;
  assign bus.wr_err  = wr_err_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_reg_file_sc.sv
// Directed bench for reg_file_sc: a 32-entry bypassing instance (a) and a
// 16-entry non-bypassing instance (b), both with the hardwired zero entry.
module tb_reg_file_sc;

  logic clk;
  logic rst_a;
  logic rst_b;
  logic dbg_a;
  logic dbg_b;
  int   checks;
  int   errors;

  reg_file_sc_if #(.ADDR_W(5), .DATA_W(32)) ifa ();
  reg_file_sc_if #(.ADDR_W(5), .DATA_W(32)) ifb ();

  reg_file_sc #(
    .DATA_W(32), .ADDR_W(5), .NUM_REGS(32), .ZERO_REG(1), .BYPASS(1)
  ) u_dut_a (
    .clk(clk), .rst(rst_a), .bus(ifa.slave), .dbg_state_o(dbg_a)
  );

  reg_file_sc #(
    .DATA_W(32), .ADDR_W(5), .NUM_REGS(16), .ZERO_REG(1), .BYPASS(0)
  ) u_dut_b (
    .clk(clk), .rst(rst_b), .bus(ifb.slave), .dbg_state_o(dbg_b)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive_write_a(input logic we, input logic [4:0] addr, input logic [31:0] dat);
    ifa.regwrite  = we;
    ifa.write_add = addr;
    ifa.write_dat = dat;
  endtask

  task automatic drive_write_b(input logic we, input logic [4:0] addr, input logic [31:0] dat);
    ifb.regwrite  = we;
    ifb.write_add = addr;
    ifb.write_dat = dat;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_a = 1'b1;
    rst_b = 1'b1;
    ifa.readreg_1 = '0; ifa.readreg_2 = '0;
    ifb.readreg_1 = '0; ifb.readreg_2 = '0;
    drive_write_a(1'b0, 5'd0, 32'h0);
    drive_write_b(1'b0, 5'd0, 32'h0);

    // Reset for two cycles
    step();
    step();
    ifa.readreg_1 = 5'd5;
    settle();
    chk("rst_ready_a", ifa.ready, 32'd0);
    chk("rst_wr_err_a", ifa.wr_err, 32'd0);
    chk("rst_regdat1_a", ifa.regdat_1, 32'h0);
    chk("rst_ready_b", ifb.ready, 32'd0);
    chk("rst_dbg_a", dbg_a, 32'd0);
    rst_a = 1'b0;
    rst_b = 1'b0;

    // Clear sweep, with a dropped write to entry 3 of (a) at the 2nd edge
    for (int e = 1; e <= 32; e++) begin
      if (e == 2) drive_write_a(1'b1, 5'd3, 32'h0000_00FF);
      step();
      drive_write_a(1'b0, 5'd0, 32'h0);
      if (e == 2) chk("clear_wr_err_pulse", ifa.wr_err, 32'd1);
      if (e == 3) chk("clear_wr_err_drop", ifa.wr_err, 32'd0);
      chk($sformatf("sweep_ready_a_e%0d", e), ifa.ready, (e == 32) ? 32'd1 : 32'd0);
      chk($sformatf("sweep_ready_b_e%0d", e), ifb.ready, (e >= 16) ? 32'd1 : 32'd0);
    end
    chk("run_dbg_a", dbg_a, 32'd1);

    for (int r = 0; r < 32; r++) begin
      ifa.readreg_1 = 5'(r);
      ifa.readreg_2 = 5'(31 - r);
      settle();
      chk($sformatf("swept_p1_r%0d", r), ifa.regdat_1, 32'h0);
      chk($sformatf("swept_p2_r%0d", 31 - r), ifa.regdat_2, 32'h0);
    end
    ifa.readreg_1 = 5'd3;
    settle();
    chk("entry3_after_clear", ifa.regdat_1, 32'h0);

    // Write entry 5, then attempt entry 0
    drive_write_a(1'b1, 5'd5, 32'hDEAD_BEEF);
    step();
    chk("wr5_wr_err", ifa.wr_err, 32'd0);
    drive_write_a(1'b1, 5'd0, 32'h1234_5678);
    step();
    chk("wr0_wr_err", ifa.wr_err, 32'd0);
    drive_write_a(1'b0, 5'd0, 32'h0);
    ifa.readreg_1 = 5'd5;
    ifa.readreg_2 = 5'd0;
    settle();
    chk("rd5", ifa.regdat_1, 32'hDEAD_BEEF);
    chk("rd0_zero", ifa.regdat_2, 32'h0);
    step();
    chk("idle_wr_err", ifa.wr_err, 32'd0);

    // Bypass on (a)
    drive_write_a(1'b1, 5'd7, 32'hA5A5_A5A5);
    ifa.readreg_1 = 5'd7;
    ifa.readreg_2 = 5'd7;
    settle();
    chk("bypass_p1", ifa.regdat_1, 32'hA5A5_A5A5);
    chk("bypass_p2", ifa.regdat_2, 32'hA5A5_A5A5);
    step();
    drive_write_a(1'b0, 5'd0, 32'h0);
    settle();
    chk("bypass_stored", ifa.regdat_1, 32'hA5A5_A5A5);

    // No bypass on (b): old value until the edge
    drive_write_b(1'b1, 5'd7, 32'h1111_1111);
    step();
    drive_write_b(1'b1, 5'd7, 32'h2222_2222);
    ifb.readreg_1 = 5'd7;
    settle();
    chk("nobypass_old", ifb.regdat_1, 32'h1111_1111);
    step();
    drive_write_b(1'b0, 5'd0, 32'h0);
    settle();
    chk("nobypass_new", ifb.regdat_1, 32'h2222_2222);

    // Out-of-range on (b)
    drive_write_b(1'b1, 5'd20, 32'hCAFE_F00D);
    ifb.readreg_1 = 5'd20;
    ifb.readreg_2 = 5'd4;
    settle();
    chk("oor_rd_before", ifb.regdat_1, 32'h0);
    step();
    drive_write_b(1'b0, 5'd0, 32'h0);
    chk("oor_wr_err_set", ifb.wr_err, 32'd1);
    settle();
    chk("oor_rd20", ifb.regdat_1, 32'h0);
    chk("oor_alias4", ifb.regdat_2, 32'h0);
    step();
    chk("oor_wr_err_clr", ifb.wr_err, 32'd0);

    // Boundary: last entry valid, first out-of-range invalid, back-to-back
    drive_write_b(1'b1, 5'd15, 32'h0F0F_0F0F);
    step();
    chk("last_wr_err", ifb.wr_err, 32'd0);
    drive_write_b(1'b1, 5'd16, 32'hBAD0_0016);
    step();
    chk("b2b_err_1", ifb.wr_err, 32'd1);
    drive_write_b(1'b1, 5'd31, 32'hBAD0_001F);
    step();
    chk("b2b_err_2", ifb.wr_err, 32'd1);
    drive_write_b(1'b0, 5'd0, 32'h0);
    ifb.readreg_1 = 5'd15;
    ifb.readreg_2 = 5'd0;
    settle();
    chk("last_rd15", ifb.regdat_1, 32'h0F0F_0F0F);
    chk("oor16_no_alias0", ifb.regdat_2, 32'h0);
    step();
    chk("b2b_err_end", ifb.wr_err, 32'd0);
    ifb.readreg_1 = 5'd7;
    settle();
    chk("oor_no_change7", ifb.regdat_1, 32'h2222_2222);

    // Reset mid-sweep on (a)
    rst_a = 1'b1;
    step();
    rst_a = 1'b0;
    ifa.readreg_1 = 5'd5;
    settle();
    chk("rst2_ready", ifa.ready, 32'd0);
    chk("rst2_rd_zero", ifa.regdat_1, 32'h0);
    for (int e = 1; e <= 9; e++) begin
      if (e == 9) drive_write_a(1'b1, 5'd6, 32'h0000_0066);
      step();
    end
    chk("mid_wr_err_pre", ifa.wr_err, 32'd1);
    rst_a = 1'b1;
    step();
    rst_a = 1'b0;
    drive_write_a(1'b0, 5'd0, 32'h0);
    chk("mid_rst_wr_err", ifa.wr_err, 32'd0);
    chk("mid_rst_ready", ifa.ready, 32'd0);
    for (int e = 1; e <= 32; e++) begin
      step();
      chk($sformatf("resweep_ready_e%0d", e), ifa.ready, (e == 32) ? 32'd1 : 32'd0);
    end
    ifa.readreg_1 = 5'd5;
    ifa.readreg_2 = 5'd7;
    settle();
    chk("resweep_rd5", ifa.regdat_1, 32'h0);
    chk("resweep_rd7", ifa.regdat_2, 32'h0);

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_file_sc.md
# reg_file_sc

Parametrised synchronous register file for the MIPS datapath. It replaces the level-triggered 16-entry array with a clocked write port, a hardwired zero register, and a write-to-read bypass. A reset-driven clear sequencer zeroes every entry one per cycle and signals `ready`, so the decode stage never reads stale or unknown data after reset.

## Interface
- `DATA_W`, 32: register width in bits.
- `ADDR_W`, 5: address width of all three address ports.
- `NUM_REGS`, 32: implemented entries. Must satisfy 2 ≤ NUM_REGS ≤ 2^ADDR_W.
- `ZERO_REG`, 1: when 1, entry 0 reads as 0 and ignores writes.
- `BYPASS`, 1: when 1, a same-cycle write is forwarded to a matching read port.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `readreg_1`  in  ADDR_W  read address, port 1.
- `readreg_2`  in  ADDR_W  read address, port 2.
- `regdat_1`  out  DATA_W  read data, port 1 (combinational).
- `regdat_2`  out  DATA_W  read data, port 2 (combinational).
- `regwrite`  in  1  write request for the current cycle.
- `write_add`  in  ADDR_W  write address.
- `write_dat`  in  DATA_W  write data.
- `ready`  out  1  high once the clear sweep is complete; writes are accepted only while high.
- `wr_err`  out  1  one-cycle registered pulse flagging a dropped write.

## Operation
- State machine `CLEAR` / `RUN`, plus a clear pointer `clr_ptr` of width ADDR_W.
- Reset behaviour:
  - `rst`=1 at an edge forces `CLEAR`, `clr_ptr`=0, `ready`=0 and `wr_err`=0.
  - No array write occurs at that edge.
  - Reset asserted at any point, including mid-sweep, restarts the sweep from entry 0.
- `CLEAR` state (each edge with `rst`=0):
  - Writes 0 to entry `clr_ptr`, then increments `clr_ptr`.
  - When the entry written is NUM_REGS-1, moves to `RUN` and sets `ready`=1 at the same edge.
  - `regwrite` is ignored.
- `RUN` state: a write is accepted at an edge when all of the following hold:
  - `regwrite`=1
  - `write_add` < NUM_REGS
  - not (ZERO_REG=1 and `write_add`=0)
  - An accepted write stores `write_dat` in entry `write_add`.
- `wr_err` is set at an edge iff `regwrite`=1 and either:
  - the block is in `CLEAR` (`ready`=0), or
  - `write_add` ≥ NUM_REGS.
  - Otherwise `wr_err` is cleared at that edge.
  - A write to entry 0 with ZERO_REG=1 is dropped silently, with no `wr_err`.
- Read path, per port, evaluated in priority order:
  1. `ready`=0 → 0.
  2. Address ≥ NUM_REGS → 0.
  3. ZERO_REG=1 and address 0 → 0.
  4. BYPASS=1 and a write is being accepted this cycle to the same address → `write_dat`.
  5. Otherwise → the array entry.
- Both read ports are independent and may use the same address.
- The array itself has no reset; its contents are defined only by the clear sweep.

## Timing
- Reset values: `ready`=0 and `wr_err`=0. `regdat_1`/`regdat_2` read 0 while `ready`=0.
- Clear latency: with `rst` low from edge E1 onward, entries 0..NUM_REGS-1 are cleared at edges E1..E_NUM_REGS, and `ready` is 1 after edge E_NUM_REGS.
- Write latency: an accepted write is visible in the array after the edge.
  - With BYPASS=1 it is also visible on the read ports in the same cycle, combinationally.
  - With BYPASS=0 the reads return the old value until the edge.
- `wr_err` is high for exactly the one cycle following the offending edge. Back-to-back offending requests keep it high.
- The cycle in which `ready` first reads 1 accepts writes normally.

## Test plan
- **Clear sweep.** NUM_REGS=32. Assert `rst` for 2 cycles, then release:
  - `ready`=0 for 31 edges and rises after the 32nd edge.
  - All 32 entries then read 0 on both ports.
- **Write/read and zero register.** Write 0xDEADBEEF to entry 5, then 0x12345678 to entry 0:
  - The next cycle, `readreg_1`=5 gives 0xDEADBEEF.
  - `readreg_2`=0 gives 0.
  - `wr_err` stays 0 throughout.
- **Bypass.** BYPASS=1: write 0xA5A5A5A5 to entry 7 with `readreg_1`=7 in the same cycle → `regdat_1`=0xA5A5A5A5 before the edge. Repeat with BYPASS=0 → `regdat_1` shows the old value until the edge.
- **Out-of-range.** NUM_REGS=16, ADDR_W=5: write to address 20 → `wr_err`=1 for one cycle, no entry changes, and reading address 20 returns 0.
- **Write during clear.** Raise `regwrite` to entry 3 (data 0xFF) at the 2nd sweep edge → `wr_err` pulses. After `ready` rises, entry 3 reads 0.
- **Reset mid-sweep.** Assert `rst` at edge 10 of the sweep:
  - `ready` stays 0.
  - The sweep restarts at entry 0.
  - `ready` rises exactly NUM_REGS edges after `rst` falls.
